// File: rtl/cayde_regfile_sb.sv
// Integer register file for the cayde core: NRD combinational read ports, one
// write-back port with write-first bypass, and a per-register pending-write scoreboard.
module cayde_regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr_in,
    output logic [NRD*XLEN-1:0] rdata_out,
    output logic [NRD-1:0]      rbusy_out,
    input  logic                wen_in,
    input  logic [AW-1:0]       waddr_in,
    input  logic [XLEN-1:0]     wdata_in,
    input  logic                iss_valid_in,
    input  logic [AW-1:0]       iss_rd_in,
    output logic                iss_ready_out,
    output logic [AW:0]         pend_cnt_out
);

    // x0 has no storage; entries 1..NREG-1 only.
    logic [XLEN-1:0] mem_q [1:NREG-1];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic wb_fire;
    logic claim_set;
    logic wb_clears;

    assign wb_fire = wen_in && (waddr_in != '0);

    // A write-back to the claimed register in the same cycle frees the slot for the new producer.
    assign iss_ready_out = iss_valid_in &&
                           ((iss_rd_in == '0) || !busy_q[iss_rd_in] ||
                            (wen_in && (waddr_in == iss_rd_in)));

    assign claim_set = iss_valid_in && iss_ready_out && (iss_rd_in != '0);
    assign wb_clears = wb_fire && busy_q[waddr_in];

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (wb_fire) begin
            busy_d[waddr_in] = 1'b0;
        end
        if (claim_set) begin
            busy_d[iss_rd_in] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(claim_set) - (AW+1)'(wb_clears);
    end

    assign pend_cnt_out = cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    // NOTE: the data array is reset too, because architectural registers must read 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wen_in && (waddr_in == AW'(r))) begin
                    mem_q[r] <= wdata_in;
                end
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] stored;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = raddr_in[p*AW +: AW];
        assign hit  = wen_in && (waddr_in == addr);

        always_comb begin
            stored = '0;
            for (int r = 1; r < NREG; r++) begin
                if (addr == AW'(r)) begin
                    stored = mem_q[r];
                end
            end
        end

        // Write-first bypass: a register being written back is never reported busy.
        always_comb begin
            data = stored;
            busy = busy_q[addr];
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end else if (hit) begin
                data = wdata_in;
                busy = 1'b0;
            end
        end

        assign rdata_out[p*XLEN +: XLEN] = data;
        assign rbusy_out[p]              = busy;
    end

endmodule

// File: tb/tb_cayde_regfile_sb.sv
// Directed bench for cayde_regfile_sb: reset, x0, read/write, bypass, scoreboard,
// counter saturation and asynchronous reset mid-operation.
module tb_cayde_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr_in;
    logic [NRD*XLEN-1:0] rdata_out;
    logic [NRD-1:0]      rbusy_out;
    logic                wen_in;
    logic [AW-1:0]       waddr_in;
    logic [XLEN-1:0]     wdata_in;
    logic                iss_valid_in;
    logic [AW-1:0]       iss_rd_in;
    logic                iss_ready_out;
    logic [AW:0]         pend_cnt_out;

    int errors = 0;
    int checks = 0;

    cayde_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk          (clk),
        .rst          (rst),
        .raddr_in     (raddr_in),
        .rdata_out    (rdata_out),
        .rbusy_out    (rbusy_out),
        .wen_in       (wen_in),
        .waddr_in     (waddr_in),
        .wdata_in     (wdata_in),
        .iss_valid_in (iss_valid_in),
        .iss_rd_in    (iss_rd_in),
        .iss_ready_out(iss_ready_out),
        .pend_cnt_out (pend_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        raddr_in = {a2, a1, a0};
    endtask

    function automatic logic [XLEN-1:0] rd(input int p);
        return rdata_out[p*XLEN +: XLEN];
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        wen_in = 1'b0; waddr_in = '0; wdata_in = '0;
        iss_valid_in = 1'b1; iss_rd_in = 5'd3;
        set_rd(5'd5, 5'd31, 5'd1);
        repeat (3) tick();
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL rst_rd0: got %h want %h", rd(0), 32'h0); end
        checks++; if (rd(1) !== 32'h0) begin errors++; $display("FAIL rst_rd1: got %h want %h", rd(1), 32'h0); end
        checks++; if (rbusy_out !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b want %b", rbusy_out, 3'b000); end
        checks++; if (pend_cnt_out !== 6'd0) begin errors++; $display("FAIL rst_pend: got %0d want 0", pend_cnt_out); end
        checks++; if (iss_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready_hi: got %b want 1", iss_ready_out); end
        iss_valid_in = 1'b0; #1;
        checks++; if (iss_ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready_lo: got %b want 0", iss_ready_out); end
        wen_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'h0000_1111; #1;
        checks++; if (rd(0) !== 32'h0000_1111) begin errors++; $display("FAIL rst_bypass: got %h want %h", rd(0), 32'h0000_1111); end
        tick();
        wen_in = 1'b0; #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL rst_no_store: got %h want %h", rd(0), 32'h0); end
        @(negedge clk);
        rst = 1'b1;
        wen_in = 1'b1; waddr_in = 5'd0; wdata_in = 32'hDEAD_BEEF;
        set_rd(5'd0, 5'd0, 5'd0); #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL x0_same_cycle: got %h want %h", rd(0), 32'h0); end
        checks++; if (rbusy_out !== 3'b000) begin errors++; $display("FAIL x0_busy: got %b want %b", rbusy_out, 3'b000); end
        tick();
        wen_in = 1'b0; #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL x0_after: got %h want %h", rd(0), 32'h0); end
        checks++; if (pend_cnt_out !== 6'd0) begin errors++; $display("FAIL x0_pend: got %0d want 0", pend_cnt_out); end
    endtask

    task automatic test_basic_rw();
        wen_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'h1234_5678;
        tick();
        waddr_in = 5'd31; wdata_in = 32'hFFFF_FFFF;
        tick();
        wen_in = 1'b0;
        set_rd(5'd5, 5'd31, 5'd0); #1;
        checks++; if (rd(0) !== 32'h1234_5678) begin errors++; $display("FAIL rw_x5: got %h want %h", rd(0), 32'h1234_5678); end
        checks++; if (rd(1) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rw_x31: got %h want %h", rd(1), 32'hFFFF_FFFF); end
        checks++; if (rd(2) !== 32'h0) begin errors++; $display("FAIL rw_x0: got %h want %h", rd(2), 32'h0); end
    endtask

    task automatic test_bypass();
        wen_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'hA5A5_A5A5;
        set_rd(5'd5, 5'd7, 5'd0); #1;
        checks++; if (rd(1) !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_data: got %h want %h", rd(1), 32'hA5A5_A5A5); end
        checks++; if (rbusy_out[1] !== 1'b0) begin errors++; $display("FAIL byp_busy: got %b want 0", rbusy_out[1]); end
        checks++; if (rd(0) !== 32'h1234_5678) begin errors++; $display("FAIL byp_other: got %h want %h", rd(0), 32'h1234_5678); end
        tick();
        wen_in = 1'b0; #1;
        checks++; if (rd(1) !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_persist: got %h want %h", rd(1), 32'hA5A5_A5A5); end
    endtask

    task automatic test_scoreboard();
        set_rd(5'd3, 5'd0, 5'd0);
        iss_valid_in = 1'b1; iss_rd_in = 5'd3; #1;
        checks++; if (iss_ready_out !== 1'b1) begin errors++; $display("FAIL sb_claim_ready: got %b want 1", iss_ready_out); end
        tick();
        iss_valid_in = 1'b0; #1;
        checks++; if (rbusy_out[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b want 1", rbusy_out[0]); end
        checks++; if (pend_cnt_out !== 6'd1) begin errors++; $display("FAIL sb_pend1: got %0d want 1", pend_cnt_out); end
        iss_valid_in = 1'b1; #1;
        checks++; if (iss_ready_out !== 1'b0) begin errors++; $display("FAIL sb_refuse: got %b want 0", iss_ready_out); end
        tick();
        checks++; if (pend_cnt_out !== 6'd1) begin errors++; $display("FAIL sb_refuse_pend: got %0d want 1", pend_cnt_out); end
        wen_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'h0000_0033; #1;
        checks++; if (iss_ready_out !== 1'b1) begin errors++; $display("FAIL sb_wb_claim_ready: got %b want 1", iss_ready_out); end
        checks++; if (rbusy_out[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_bypass_busy: got %b want 0", rbusy_out[0]); end
        tick();
        wen_in = 1'b0; iss_valid_in = 1'b0; #1;
        checks++; if (rbusy_out[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", rbusy_out[0]); end
        checks++; if (pend_cnt_out !== 6'd1) begin errors++; $display("FAIL sb_set_wins_pend: got %0d want 1", pend_cnt_out); end
        checks++; if (rd(0) !== 32'h0000_0033) begin errors++; $display("FAIL sb_set_wins_data: got %h want %h", rd(0), 32'h0000_0033); end
        wen_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'h0000_0044;
        tick();
        wen_in = 1'b0; #1;
        checks++; if (rbusy_out[0] !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", rbusy_out[0]); end
        checks++; if (pend_cnt_out !== 6'd0) begin errors++; $display("FAIL sb_pend0: got %0d want 0", pend_cnt_out); end
        checks++; if (rd(0) !== 32'h0000_0044) begin errors++; $display("FAIL sb_wb_data: got %h want %h", rd(0), 32'h0000_0044); end
        iss_valid_in = 1'b1; iss_rd_in = 5'd0; #1;
        checks++; if (iss_ready_out !== 1'b1) begin errors++; $display("FAIL sb_x0_ready: got %b want 1", iss_ready_out); end
        tick();
        iss_valid_in = 1'b0; #1;
        checks++; if (pend_cnt_out !== 6'd0) begin errors++; $display("FAIL sb_x0_pend: got %0d want 0", pend_cnt_out); end
    endtask

    task automatic test_saturation();
        for (int r = 1; r < NREG; r++) begin
            iss_valid_in = 1'b1; iss_rd_in = AW'(r); #1;
            checks++; if (iss_ready_out !== 1'b1) begin errors++; $display("FAIL sat_claim_ready r=%0d: got %b want 1", r, iss_ready_out); end
            tick();
        end
        iss_valid_in = 1'b0; #1;
        checks++; if (pend_cnt_out !== 6'd31) begin errors++; $display("FAIL sat_full: got %0d want 31", pend_cnt_out); end
        for (int r = NREG - 1; r >= 1; r--) begin
            wen_in = 1'b1; waddr_in = AW'(r); wdata_in = 32'h0100_0000 | r;
            set_rd(5'd0, 5'd0, AW'(r)); #1;
            checks++; if (rbusy_out[2] !== 1'b0) begin errors++; $display("FAIL sat_bypass_busy r=%0d: got %b want 0", r, rbusy_out[2]); end
            tick();
            checks++; if (pend_cnt_out !== 6'(r - 1)) begin errors++; $display("FAIL sat_dec r=%0d: got %0d want %0d", r, pend_cnt_out, r - 1); end
        end
        wen_in = 1'b0;
        set_rd(5'd1, 5'd16, 5'd31); #1;
        checks++; if (rd(0) !== 32'h0100_0001) begin errors++; $display("FAIL sat_x1: got %h want %h", rd(0), 32'h0100_0001); end
        checks++; if (rd(1) !== 32'h0100_0010) begin errors++; $display("FAIL sat_x16: got %h want %h", rd(1), 32'h0100_0010); end
        checks++; if (rd(2) !== 32'h0100_001F) begin errors++; $display("FAIL sat_x31: got %h want %h", rd(2), 32'h0100_001F); end
        checks++; if (rbusy_out !== 3'b000) begin errors++; $display("FAIL sat_all_free: got %b want %b", rbusy_out, 3'b000); end
        wen_in = 1'b1; waddr_in = 5'd10; wdata_in = 32'hCAFE_0010;
        tick();
        wen_in = 1'b0;
        set_rd(5'd10, 5'd0, 5'd0); #1;
        checks++; if (pend_cnt_out !== 6'd0) begin errors++; $display("FAIL wb_nonbusy_pend: got %0d want 0", pend_cnt_out); end
        checks++; if (rbusy_out[0] !== 1'b0) begin errors++; $display("FAIL wb_nonbusy_busy: got %b want 0", rbusy_out[0]); end
        checks++; if (rd(0) !== 32'hCAFE_0010) begin errors++; $display("FAIL wb_nonbusy_data: got %h want %h", rd(0), 32'hCAFE_0010); end
    endtask

    task automatic test_async_reset();
        wen_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'h0000_0055;
        tick();
        wen_in = 1'b0; iss_valid_in = 1'b1; iss_rd_in = 5'd9;
        tick();
        iss_valid_in = 1'b0;
        set_rd(5'd9, 5'd0, 5'd0); #1;
        checks++; if (rd(0) !== 32'h0000_0055) begin errors++; $display("FAIL ar_pre_data: got %h want %h", rd(0), 32'h0000_0055); end
        checks++; if (rbusy_out[0] !== 1'b1) begin errors++; $display("FAIL ar_pre_busy: got %b want 1", rbusy_out[0]); end
        checks++; if (pend_cnt_out !== 6'd1) begin errors++; $display("FAIL ar_pre_pend: got %0d want 1", pend_cnt_out); end
        #1 rst = 1'b0;
        #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL ar_data: got %h want %h", rd(0), 32'h0); end
        checks++; if (rbusy_out[0] !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", rbusy_out[0]); end
        checks++; if (pend_cnt_out !== 6'd0) begin errors++; $display("FAIL ar_pend: got %0d want 0", pend_cnt_out); end
        #1 rst = 1'b1;
        iss_valid_in = 1'b1; iss_rd_in = 5'd9; #1;
        checks++; if (iss_ready_out !== 1'b1) begin errors++; $display("FAIL ar_claim_ready: got %b want 1", iss_ready_out); end
        tick();
        iss_valid_in = 1'b0; #1;
        checks++; if (pend_cnt_out !== 6'd1) begin errors++; $display("FAIL ar_first_edge: got %0d want 1", pend_cnt_out); end
        checks++; if (rbusy_out[0] !== 1'b1) begin errors++; $display("FAIL ar_busy_after: got %b want 1", rbusy_out[0]); end
    endtask

    initial begin
        rst = 1'b0;
        raddr_in = '0;
        wen_in = 1'b0; waddr_in = '0; wdata_in = '0;
        iss_valid_in = 1'b0; iss_rd_in = '0;
        test_reset();
        test_basic_rw();
        test_bypass();
        test_scoreboard();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cayde_regfile_sb.md
# cayde_regfile_sb

Parametrised integer register file with a pending-write scoreboard for the cayde RISC-V core. It provides NRD combinational read ports, one write-back port and write-to-read bypass, and holds x0 at zero. A per-register busy bit is set when an instruction issues with a destination and cleared at write-back. Issue of a second in-flight writer to a busy register is refused through a ready handshake. It sits between decode/issue and execute/write-back, replacing the fixed two-port, 32-entry register file.

## Interface
- XLEN, 32: register width in bits.
- NREG, 32: number of architectural registers, power of two, at least 2. AW = $clog2(NREG).
- NRD, 2: number of read ports, at least 1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- raddr_in  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata_out  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rbusy_out  out  NRD  busy flag of each addressed register, after write-back bypass.
- wen_in  in  1  write-back enable.
- waddr_in  in  AW  write-back address.
- wdata_in  in  XLEN  write-back data.
- iss_valid_in  in  1  an issuing instruction claims destination iss_rd_in.
- iss_rd_in  in  AW  destination register of the issuing instruction.
- iss_ready_out  out  1  claim accepted this cycle.
- pend_cnt_out  out  AW+1  number of busy registers.

## Operation
- Storage: registers 1..NREG-1 are XLEN-bit flops. Register 0 has no storage.
- Reads are combinational, with no read-side enable:
  - raddr 0: data is 0 and busy is 0.
  - wen_in=1 and waddr_in equals raddr (nonzero): data is wdata_in (write-first bypass) and busy is 0.
  - Otherwise: data is the stored value and busy is that register's busy bit.
- Write-back: wen_in=1 with waddr_in nonzero stores wdata_in at the edge and clears busy[waddr_in]. Writes to address 0 are discarded and change nothing.
- Write-back does not require the target to be busy. A write to a non-busy register updates data; busy stays 0.
- Issue handshake: iss_ready_out = iss_valid_in AND (iss_rd_in==0 OR busy[iss_rd_in]==0 OR (wen_in AND waddr_in==iss_rd_in)).
- A claim fires when iss_valid_in and iss_ready_out are both high. If iss_rd_in is nonzero, it sets busy[iss_rd_in] at the edge. A claim of x0 is accepted and sets nothing.
- Same-cycle write-back and claim of the same register: the data write happens, and set wins, so busy ends at 1 (the new producer owns it).
- A refused claim (iss_valid_in=1, iss_ready_out=0) changes no state. The issuer holds iss_valid_in and iss_rd_in until ready; stalling is upstream's responsibility.
- pend_cnt_out is a registered counter updated as: count + (claim set occurs) − (write-back clears a busy bit).
  - Net change per cycle is in {−1, 0, +1}.
  - It always equals popcount(busy). Maximum value is NREG−1.
- Arithmetic: no overflow is possible, because each register can hold only one pending set and x0 is excluded.

## Timing
- Reset (rst=0, asynchronous): all data registers, all busy bits and pend_cnt_out go to 0 immediately, regardless of clk.
- While rst=0, rdata_out shows 0 for all addresses (or the bypass value when wen_in is active), rbusy_out is 0 and iss_ready_out equals iss_valid_in. No edge updates state while rst=0.
- Reset deassertion mid-operation: the first rising edge with rst=1 performs normal updates. In-flight claims from before reset are forgotten.
- Read latency is 0 cycles. Write-back is visible combinationally in the same cycle via the bypass, and from storage from the next cycle.
- Busy set by a claim in cycle N is visible on rbusy_out and in pend_cnt_out from cycle N+1.
- Busy clear by a write-back in cycle N is visible on rbusy_out in cycle N through the bypass. pend_cnt_out shows it from cycle N+1.
- iss_ready_out is purely combinational from current state and inputs. There is no combinational path from rdata_out into iss_ready_out.

## Test plan
- Reset/x0: hold rst=0, pulse clk, then release. All reads return 0 and pend_cnt_out=0. Writing 0xDEADBEEF to x0 and then reading x0 returns 0 with busy 0.
- Basic write/read, NRD=3: write x5=0x12345678, x31=0xFFFFFFFF. Next cycle, read ports {5,31,0} return {0x12345678, 0xFFFFFFFF, 0}.
- Bypass: wen_in=1, waddr=7, wdata=0xA5A5A5A5 with raddr port1=7 in the same cycle. rdata port1=0xA5A5A5A5 and rbusy port1=0 that cycle, and the value persists next cycle.
- Scoreboard handshake:
  - Claim x3: ready=1, then busy(x3)=1 and pend_cnt=1.
  - Claim x3 again: ready=0, and pend_cnt stays 1.
  - Write back x3 in the same cycle as the repeated claim: ready=1, busy stays 1, pend_cnt stays 1.
  - A write-back to x3 alone then gives busy=0 and pend_cnt=0.
- Counter saturation: claim x1..x(NREG−1) on consecutive cycles, giving pend_cnt=NREG−1. Write back all of them in reverse order, with pend_cnt decrementing by 1 per cycle to 0.
- Async reset mid-operation: with x9 busy and holding 0x55, assert rst between clock edges. x9 reads 0 and pend_cnt=0 before the next edge, and a claim of x9 after release gets ready=1.
